// File: rtl/fir_tap_line_if.sv
// Valid/ready stream bundle used for both the sample input and the result
// output of fir_tap_line. The master drives valid/data; the slave drives ready.
interface fir_tap_line_if #(
    parameter int DATA_WIDTH = 32
);
    logic                         valid;
    logic                         ready;
    logic signed [DATA_WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/fir_tap_line.sv
// fir_tap_line: sample delay line and coefficient bank in front of a
// combinational MAC. One sample is shifted in per input handshake, the MAC
// result is captured on the following edge and held on the output stream
// until downstream accepts it. Coefficient writes are only honoured while no
// result is in flight, so a captured result never mixes old and new weights.
//
// Optional build macro: TAP_FLUSH_EN adds a 'flush' input that clears the
// delay line and abandons any pending result while keeping the coefficients.
module fir_tap_line #(
    parameter int DATA_WIDTH = 32,
    parameter int Q_FORMAT   = 16,
    parameter int NUM_REGS   = 8,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef TAP_FLUSH_EN
    input  logic                         flush,
`endif
    fir_tap_line_if.slave                in_if,
    input  logic                         coef_wr_en,
    input  logic [ADDR_WIDTH-1:0]        coef_addr,
    input  logic signed [DATA_WIDTH-1:0] coef_wr_data,
    output logic                         coef_drop,
    output logic signed [DATA_WIDTH-1:0] pDataOut [0:NUM_REGS-1],
    output logic signed [DATA_WIDTH-1:0] coefsOut [0:NUM_REGS-1],
    input  logic signed [DATA_WIDTH-1:0] macResultIn,
    fir_tap_line_if.master               out_if
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // The fixed-point format is carried for the MAC's benefit only; the
    // fractional field must still fit inside the word.
    if (Q_FORMAT >= DATA_WIDTH || Q_FORMAT < 0) begin : g_qcheck
        $error("fir_tap_line: Q_FORMAT must lie in [0, DATA_WIDTH)");
    end

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        HOLD
    } state_t;

    state_t           state;
    logic             flush_req;
    logic             coef_write_ok;
    logic [IDX_W-1:0] wr_idx;

    // Addresses past the last coefficient are rejected in every state.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < NUM_REGS;
    endfunction

`ifdef TAP_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    assign wr_idx        = IDX_W'(coef_addr);
    assign coef_write_ok = (state == IDLE) && addr_in_range(coef_addr);

    // Control FSM, delay line and result register; flush and reset both return to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            in_if.ready  <= 1'b1;
            out_if.valid <= 1'b0;
            out_if.data  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                pDataOut[i] <= '0;
            end
        end else if (flush_req) begin
            state        <= IDLE;
            in_if.ready  <= 1'b1;
            out_if.valid <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                pDataOut[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_if.valid) begin
                        pDataOut[0] <= in_if.data;
                        for (int i = NUM_REGS - 1; i > 0; i--) begin
                            pDataOut[i] <= pDataOut[i-1];
                        end
                        in_if.ready <= 1'b0;
                        state       <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Taps and coefficients were frozen last edge, so the MAC has settled.
                    out_if.data  <= macResultIn;
                    out_if.valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (out_if.ready) begin
                        out_if.valid <= 1'b0;
                        in_if.ready  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    out_if.valid <= 1'b0;
                    in_if.ready  <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Coefficient bank: writes land only in IDLE and in range, otherwise a one-cycle drop pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_drop <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                coefsOut[i] <= '0;
            end
        end else begin
            coef_drop <= 1'b0;
            if (coef_wr_en) begin
                if (coef_write_ok) begin
                    coefsOut[wr_idx] <= coef_wr_data;
                end else begin
                    coef_drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_line.sv
// Directed testbench for fir_tap_line. A behavioural MAC (sum of tap*coef,
// shifted right by Q) closes the loop; expected outputs are hand-computed.
module tb_fir_tap_line;

    localparam int DW = 32;
    localparam int Q  = 16;
    localparam int NR = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 coef_wr_en;
    logic [AW-1:0]        coef_addr;
    logic signed [DW-1:0] coef_wr_data;
    logic                 coef_drop;
    logic signed [DW-1:0] taps  [0:NR-1];
    logic signed [DW-1:0] coefs [0:NR-1];
    logic signed [DW-1:0] mac;
`ifdef TAP_FLUSH_EN
    logic                 flush;
`endif

    fir_tap_line_if #(.DATA_WIDTH(DW)) in_if ();
    fir_tap_line_if #(.DATA_WIDTH(DW)) out_if ();

    fir_tap_line #(
        .DATA_WIDTH (DW),
        .Q_FORMAT   (Q),
        .NUM_REGS   (NR),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef TAP_FLUSH_EN
        .flush        (flush),
`endif
        .in_if        (in_if),
        .coef_wr_en   (coef_wr_en),
        .coef_addr    (coef_addr),
        .coef_wr_data (coef_wr_data),
        .coef_drop    (coef_drop),
        .pDataOut     (taps),
        .coefsOut     (coefs),
        .macResultIn  (mac),
        .out_if       (out_if)
    );

    // Behavioural MAC standing in for the downstream combinational stage
    logic signed [63:0] acc;
    always_comb begin
        acc = '0;
        for (int i = 0; i < NR; i++) begin
            acc = acc + 64'(taps[i]) * 64'(coefs[i]);
        end
        mac = DW'(acc >>> Q);
    end

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        coef_wr_en   = 1'b0;
        coef_addr    = '0;
        coef_wr_data = '0;
`ifdef TAP_FLUSH_EN
        flush        = 1'b0;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load_coefs(input logic signed [DW-1:0] v);
        for (int i = 0; i < NR; i++) begin
            coef_wr_en   = 1'b1;
            coef_addr    = AW'(i);
            coef_wr_data = v;
            tick();
        end
        coef_wr_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        coef_wr_en   = 1'b0;
        coef_addr    = '0;
        coef_wr_data = '0;
`ifdef TAP_FLUSH_EN
        flush        = 1'b0;
`endif
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (out_if.valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %0b want 0", out_if.valid);
        end
        total++;
        if (out_if.data !== 32'sh0) begin
            bad++; $display("FAIL reset_out_data: got %h want 00000000", out_if.data);
        end
        total++;
        if (coef_drop !== 1'b0) begin
            bad++; $display("FAIL reset_coef_drop: got %0b want 0", coef_drop);
        end
        for (int i = 0; i < NR; i++) begin
            total++;
            if (taps[i] !== 32'sh0 || coefs[i] !== 32'sh0) begin
                bad++; $display("FAIL reset_regs[%0d]: tap %h coef %h want 0", i, taps[i], coefs[i]);
            end
        end
        rst = 1'b0;
        tick();
        total++;
        if (in_if.ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %0b want 1", in_if.ready);
        end
    endtask

    task automatic test_taps();
        int exp_sum [8] = '{1, 3, 6, 10, 15, 21, 28, 36};
        apply_reset();
        load_coefs(32'sh00010000);
        total++;
        if (coefs[5] !== 32'sh00010000) begin
            bad++; $display("FAIL taps_coef_load: got %h want 00010000", coefs[5]);
        end
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            total++;
            if (in_if.ready !== 1'b1) begin
                bad++; $display("FAIL taps_accept_spacing[%0d]: in_ready %0b want 1", n, in_if.ready);
            end
            in_if.data = DW'(n * 65536);
            tick();
            total++;
            if (out_if.valid !== 1'b0 || in_if.ready !== 1'b0) begin
                bad++; $display("FAIL taps_capture_state[%0d]: out_valid %0b in_ready %0b want 0 0", n, out_if.valid, in_if.ready);
            end
            tick();
            total++;
            if (out_if.valid !== 1'b1 || out_if.data !== DW'(exp_sum[n-1] * 65536)) begin
                bad++; $display("FAIL taps_out[%0d]: valid %0b data %h want 1 %h", n, out_if.valid, out_if.data, exp_sum[n-1] * 65536);
            end
            tick();
        end
        in_if.valid = 1'b0;
        total++;
        if (taps[7] !== 32'sh00010000 || taps[0] !== 32'sh00080000) begin
            bad++; $display("FAIL taps_line_order: tap0 %h tap7 %h want 00080000 00010000", taps[0], taps[7]);
        end
    endtask

    task automatic test_impulse();
        apply_reset();
        load_coefs(32'sh00003333);
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        for (int n = 0; n < 9; n++) begin
            in_if.data = (n == 0) ? 32'sh00010000 : 32'sh0;
            tick();
            tick();
            total++;
            if (out_if.valid !== 1'b1 || out_if.data !== ((n < 8) ? 32'sh00003333 : 32'sh0)) begin
                bad++; $display("FAIL impulse_out[%0d]: valid %0b data %h want 1 %h", n, out_if.valid, out_if.data, (n < 8) ? 32'sh00003333 : 32'sh0);
            end
            tick();
        end
        in_if.valid = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        load_coefs(32'sh00010000);
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 32'sh00020000;
        tick();
        tick();
        total++;
        if (out_if.valid !== 1'b1 || out_if.data !== 32'sh00020000) begin
            bad++; $display("FAIL bp_first_out: valid %0b data %h want 1 00020000", out_if.valid, out_if.data);
        end
        in_if.data = 32'sh00050000;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (out_if.data !== 32'sh00020000 || in_if.ready !== 1'b0 || out_if.valid !== 1'b1 || taps[0] !== 32'sh00020000) begin
                bad++; $display("FAIL bp_hold[%0d]: data %h rdy %0b vld %0b tap0 %h want 00020000 0 1 00020000", c, out_if.data, in_if.ready, out_if.valid, taps[0]);
            end
        end
        out_if.ready = 1'b1;
        tick();
        total++;
        if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: vld %0b rdy %0b want 0 1", out_if.valid, in_if.ready);
        end
        tick();
        total++;
        if (taps[0] !== 32'sh00050000 || taps[1] !== 32'sh00020000) begin
            bad++; $display("FAIL bp_next_accept: tap0 %h tap1 %h want 00050000 00020000", taps[0], taps[1]);
        end
        in_if.valid = 1'b0;
        tick();
        total++;
        if (out_if.data !== 32'sh00070000) begin
            bad++; $display("FAIL bp_next_out: got %h want 00070000", out_if.data);
        end
        tick();
    endtask

    // Runs on the state left by test_backpressure: coefs 1.0, taps 5,2, IDLE
    task automatic test_coef_drop();
        in_if.valid = 1'b1;
        in_if.data  = 32'sh00010000;
        tick();
        in_if.valid  = 1'b0;
        coef_wr_en   = 1'b1;
        coef_addr    = 4'd2;
        coef_wr_data = 32'sh00020000;
        tick();
        coef_wr_en = 1'b0;
        total++;
        if (coef_drop !== 1'b1 || coefs[2] !== 32'sh00010000) begin
            bad++; $display("FAIL drop_capture: drop %0b coef2 %h want 1 00010000", coef_drop, coefs[2]);
        end
        total++;
        if (out_if.data !== 32'sh00080000) begin
            bad++; $display("FAIL drop_result_intact: got %h want 00080000", out_if.data);
        end
        tick();
        total++;
        if (coef_drop !== 1'b0) begin
            bad++; $display("FAIL drop_single_pulse: got %0b want 0", coef_drop);
        end
        coef_wr_en   = 1'b1;
        coef_addr    = 4'd9;
        coef_wr_data = 32'sh00020000;
        tick();
        coef_wr_en = 1'b0;
        total++;
        if (coef_drop !== 1'b1 || coefs[1] !== 32'sh00010000) begin
            bad++; $display("FAIL drop_addr9: drop %0b coef1 %h want 1 00010000", coef_drop, coefs[1]);
        end
        tick();
        coef_wr_en   = 1'b1;
        coef_addr    = 4'd3;
        coef_wr_data = 32'sh00030000;
        tick();
        coef_wr_en = 1'b0;
        total++;
        if (coef_drop !== 1'b0 || coefs[3] !== 32'sh00030000) begin
            bad++; $display("FAIL idle_write: drop %0b coef3 %h want 0 00030000", coef_drop, coefs[3]);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        apply_reset();
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        in_if.data   = 32'sh00030000;
        coef_wr_en   = 1'b1;
        coef_addr    = 4'd0;
        coef_wr_data = 32'sh00020000;
        tick();
        in_if.valid = 1'b0;
        coef_wr_en  = 1'b0;
        total++;
        if (coefs[0] !== 32'sh00020000 || taps[0] !== 32'sh00030000 || coef_drop !== 1'b0) begin
            bad++; $display("FAIL simul_edge: coef0 %h tap0 %h drop %0b want 00020000 00030000 0", coefs[0], taps[0], coef_drop);
        end
        tick();
        total++;
        if (out_if.data !== 32'sh00060000) begin
            bad++; $display("FAIL simul_result: got %h want 00060000", out_if.data);
        end
        tick();
    endtask

    task automatic test_reset_hold();
        apply_reset();
        load_coefs(32'sh00010000);
        out_if.ready = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 32'sh00040000;
        tick();
        in_if.valid = 1'b0;
        tick();
        total++;
        if (out_if.valid !== 1'b1 || out_if.data !== 32'sh00040000) begin
            bad++; $display("FAIL rsthold_pre: vld %0b data %h want 1 00040000", out_if.valid, out_if.data);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (out_if.valid !== 1'b0) begin
            bad++; $display("FAIL rsthold_async_valid: got %0b want 0", out_if.valid);
        end
        total++;
        if (taps[0] !== 32'sh0 || coefs[0] !== 32'sh0 || coefs[7] !== 32'sh0 || out_if.data !== 32'sh0) begin
            bad++; $display("FAIL rsthold_clear: tap0 %h coef0 %h coef7 %h data %h want 0", taps[0], coefs[0], coefs[7], out_if.data);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        in_if.data   = 32'sh00030000;
        tick();
        in_if.valid = 1'b0;
        tick();
        total++;
        if (out_if.valid !== 1'b1 || out_if.data !== 32'sh0) begin
            bad++; $display("FAIL rsthold_post_out: vld %0b data %h want 1 00000000", out_if.valid, out_if.data);
        end
        tick();
    endtask

`ifdef TAP_FLUSH_EN
    task automatic test_flush();
        apply_reset();
        load_coefs(32'sh00010000);
        out_if.ready = 1'b1;
        in_if.valid  = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            in_if.data = DW'(n * 65536);
            tick();
            tick();
            tick();
        end
        total++;
        if (taps[0] !== 32'sh00030000) begin
            bad++; $display("FAIL flush_fill: tap0 %h want 00030000", taps[0]);
        end
        flush      = 1'b1;
        in_if.data = 32'sh00090000;
        tick();
        flush       = 1'b0;
        in_if.valid = 1'b0;
        for (int i = 0; i < NR; i++) begin
            total++;
            if (taps[i] !== 32'sh0 || coefs[i] !== 32'sh00010000) begin
                bad++; $display("FAIL flush_regs[%0d]: tap %h coef %h want 0 00010000", i, taps[i], coefs[i]);
            end
        end
        total++;
        if (out_if.valid !== 1'b0 || in_if.ready !== 1'b1) begin
            bad++; $display("FAIL flush_state: vld %0b rdy %0b want 0 1", out_if.valid, in_if.ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_taps();
        test_impulse();
        test_backpressure();
        test_coef_drop();
        test_simultaneous();
        test_reset_hold();
`ifdef TAP_FLUSH_EN
        test_flush();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
